// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the multicycle datapath.
// Define CU_MEM_WAIT_EN to stretch memory states until mem_done.
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        CON,
    input  logic        mem_done,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        Cout,
    output logic        PCin,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        Yin,
    output logic        Zin,
    output logic        CONin,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic [3:0]  alu_op,
    output logic        run
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_T7,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_R,
        C_I,
        C_LD,
        C_LDI,
        C_ST,
        C_BR,
        C_JR,
        C_NOP,
        C_HALT
    } cls_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SHR = 4'b0100;
    localparam logic [3:0] ALU_SHL = 4'b0101;
    localparam logic [3:0] ALU_ROR = 4'b0110;
    localparam logic [3:0] ALU_ROL = 4'b0111;

    state_t     state;
    cls_t       cls;
    logic [3:0] alu_sel;
    logic [4:0] opcode;
    logic       mem_ok;

    assign opcode = IR[31:27];

`ifdef CU_MEM_WAIT_EN
    assign mem_ok = mem_done;
    logic unused_ir;
    assign unused_ir = ^IR[26:0];
`else
    // Memory states always complete in one cycle in this build.
    assign mem_ok = 1'b1;
    logic unused_in;
    assign unused_in = ^{mem_done, IR[26:0]};
`endif

    // Classify the opcode and pick the ALU function for R/I classes.
    always_comb begin
        cls     = C_NOP;
        alu_sel = ALU_ADD;
        case (opcode)
            5'b00011: begin cls = C_R; alu_sel = ALU_ADD; end
            5'b00100: begin cls = C_R; alu_sel = ALU_SUB; end
            5'b00101: begin cls = C_R; alu_sel = ALU_AND; end
            5'b00110: begin cls = C_R; alu_sel = ALU_OR;  end
            5'b00111: begin cls = C_R; alu_sel = ALU_SHR; end
            5'b01000: begin cls = C_R; alu_sel = ALU_SHL; end
            5'b01001: begin cls = C_R; alu_sel = ALU_ROR; end
            5'b01010: begin cls = C_R; alu_sel = ALU_ROL; end
            5'b01011: begin cls = C_I; alu_sel = ALU_ADD; end
            5'b01100: begin cls = C_I; alu_sel = ALU_AND; end
            5'b01101: begin cls = C_I; alu_sel = ALU_OR;  end
            5'b00000: cls = C_LD;
            5'b00001: cls = C_LDI;
            5'b00010: cls = C_ST;
            5'b10010: cls = C_BR;
            5'b10100: cls = C_JR;
            5'b11011: cls = C_HALT;
            default:  cls = C_NOP;
        endcase
    end

    // State register: clear aborts to IDLE at once, memory states may stall.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: state <= S_T0;
                S_T0:   state <= S_T1;
                S_T1:   state <= mem_ok ? S_T2 : S_T1;
                S_T2:   state <= S_T3;
                S_T3: begin
                    case (cls)
                        C_HALT:      state <= S_HALT;
                        C_JR, C_NOP: state <= S_T0;
                        default:     state <= S_T4;
                    endcase
                end
                S_T4:   state <= S_T5;
                S_T5: begin
                    case (cls)
                        C_LD, C_ST, C_BR: state <= S_T6;
                        default:          state <= S_T0;
                    endcase
                end
                S_T6: begin
                    case (cls)
                        C_LD:    state <= mem_ok ? S_T7 : S_T6;
                        C_ST:    state <= S_T7;
                        default: state <= S_T0;
                    endcase
                end
                S_T7: begin
                    if (cls == C_ST) begin
                        state <= mem_ok ? S_T0 : S_T7;
                    end else begin
                        state <= S_T0;
                    end
                end
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobe decode from the current step and instruction class.
    always_comb begin
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        Rin     = 1'b0;
        Rout    = 1'b0;
        BAout   = 1'b0;
        PCout   = 1'b0;
        Zlowout = 1'b0;
        MDRout  = 1'b0;
        Cout    = 1'b0;
        PCin    = 1'b0;
        IRin    = 1'b0;
        MARin   = 1'b0;
        MDRin   = 1'b0;
        Yin     = 1'b0;
        Zin     = 1'b0;
        CONin   = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        alu_op  = ALU_ADD;
        run     = 1'b1;
        case (state)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                case (cls)
                    C_R, C_I: begin
                        Grb  = 1'b1;
                        Rout = 1'b1;
                        Yin  = 1'b1;
                    end
                    C_LD, C_LDI, C_ST: begin
                        Grb   = 1'b1;
                        BAout = 1'b1;
                        Yin   = 1'b1;
                    end
                    C_BR: begin
                        Gra   = 1'b1;
                        Rout  = 1'b1;
                        CONin = 1'b1;
                    end
                    C_JR: begin
                        Gra  = 1'b1;
                        Rout = 1'b1;
                        PCin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    C_R: begin
                        Grc    = 1'b1;
                        Rout   = 1'b1;
                        Zin    = 1'b1;
                        alu_op = alu_sel;
                    end
                    C_I: begin
                        Cout   = 1'b1;
                        Zin    = 1'b1;
                        alu_op = alu_sel;
                    end
                    C_LD, C_LDI, C_ST: begin
                        Cout = 1'b1;
                        Zin  = 1'b1;
                    end
                    C_BR: begin
                        PCout = 1'b1;
                        Yin   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    C_R, C_I, C_LDI: begin
                        Zlowout = 1'b1;
                        Gra     = 1'b1;
                        Rin     = 1'b1;
                    end
                    C_LD, C_ST: begin
                        Zlowout = 1'b1;
                        MARin   = 1'b1;
                    end
                    C_BR: begin
                        Cout = 1'b1;
                        Zin  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
                    C_LD: begin
                        Read  = 1'b1;
                        MDRin = 1'b1;
                    end
                    C_ST: begin
                        Gra   = 1'b1;
                        Rout  = 1'b1;
                        MDRin = 1'b1;
                    end
                    C_BR: begin
                        Zlowout = CON;
                        PCin    = CON;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls)
                    C_LD: begin
                        MDRout = 1'b1;
                        Gra    = 1'b1;
                        Rin    = 1'b1;
                    end
                    C_ST: Write = 1'b1;
                    default: ;
                endcase
            end
            S_HALT: run = 1'b0;
            default: ;
        endcase
    end

endmodule
